// File: rtl/sonic_sprite_pkg.sv
// Shared constants and types for the Sonic sprite fetch stage and its palette.
package sonic_sprite_pkg;

  localparam int SPRITE_W        = 40;
  localparam int SPRITE_H        = 40;
  localparam int FRAMES          = 4;
  localparam int TRANSPARENT_IDX = 0;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] pal_idx_t;

endpackage

// File: rtl/sonic_anim_ctrl.sv
// Per-frame geometry latches and the animation frame counter, both advanced only on vsync.
module sonic_anim_ctrl
  import sonic_sprite_pkg::*;
#(
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  localparam int FW      = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int DW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vsync_pulse,
  input  logic          moving,
  input  coord_t        sprite_x,
  input  coord_t        sprite_y,
  input  logic          facing_left,
  output coord_t        pos_x_q,
  output coord_t        pos_y_q,
  output logic          face_q,
  output logic [FW-1:0] frame_sel
);

  logic [DW-1:0] div_cnt;

  // Standing still snaps straight back to the standing frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      face_q    <= 1'b0;
      div_cnt   <= '0;
      frame_sel <= '0;
    end else if (vsync_pulse) begin
      pos_x_q <= sprite_x;
      pos_y_q <= sprite_y;
      face_q  <= facing_left;
      if (!moving) begin
        div_cnt   <= '0;
        frame_sel <= '0;
      end else if (div_cnt == DW'(ANIM_DIV - 1)) begin
        div_cnt   <= '0;
        frame_sel <= (frame_sel == FW'(FRAMES - 1)) ? '0 : frame_sel + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sonic_sprite_fetch.sv
// Hit test and sprite ROM address pipeline feeding the palette: 3-cycle latency, 1 pixel/clock.
module sonic_sprite_fetch
  import sonic_sprite_pkg::*;
#(
  parameter int SPRITE_W        = sonic_sprite_pkg::SPRITE_W,
  parameter int SPRITE_H        = sonic_sprite_pkg::SPRITE_H,
  parameter int FRAMES          = sonic_sprite_pkg::FRAMES,
  parameter int ANIM_DIV        = 8,
  parameter int ROM_AW          = 13,
  parameter int TRANSPARENT_IDX = sonic_sprite_pkg::TRANSPARENT_IDX,
  localparam int FW             = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  coord_t            draw_x,
  input  coord_t            draw_y,
  input  logic              blank,
  input  logic              vsync_pulse,
  input  coord_t            sprite_x,
  input  coord_t            sprite_y,
  input  logic              facing_left,
  input  logic              moving,
  output logic [ROM_AW-1:0] rom_addr,
  input  pal_idx_t          rom_data,
  output pal_idx_t          pixel_index,
  output logic              pixel_valid,
  output logic [FW-1:0]     frame_sel
);

  coord_t pos_x_q;
  coord_t pos_y_q;
  logic   face_q;

  sonic_anim_ctrl #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_pulse (vsync_pulse),
    .moving      (moving),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .facing_left (facing_left),
    .pos_x_q     (pos_x_q),
    .pos_y_q     (pos_y_q),
    .face_q      (face_q),
    .frame_sel   (frame_sel)
  );

  // Bounds are compared at 11 bits so a sprite hanging off the right/bottom edge clips instead of wrapping.
  logic [10:0] px, py, dx, dy;
  logic        hit;
  coord_t      lx, ly, col;

  assign px  = {1'b0, pos_x_q};
  assign py  = {1'b0, pos_y_q};
  assign dx  = {1'b0, draw_x};
  assign dy  = {1'b0, draw_y};
  assign hit = !blank && (dx >= px) && (dx < px + 11'(SPRITE_W))
                      && (dy >= py) && (dy < py + 11'(SPRITE_H));
  assign lx  = draw_x - pos_x_q;
  assign ly  = draw_y - pos_y_q;
  assign col = face_q ? coord_t'(SPRITE_W - 1) - lx : lx;

  logic hit1, hit2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr    <= '0;
      hit1        <= 1'b0;
      hit2        <= 1'b0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
    end else begin
      rom_addr    <= hit ? ROM_AW'(int'(frame_sel) * SPRITE_W * SPRITE_H
                                   + int'(ly) * SPRITE_W + int'(col)) : '0;
      hit1        <= hit;
      hit2        <= hit1;
      pixel_index <= rom_data;
      pixel_valid <= hit2 && (rom_data != pal_idx_t'(TRANSPARENT_IDX));
    end
  end

endmodule

// File: tb/tb_sonic_sprite_fetch.sv
// Self-checking bench for sonic_sprite_fetch: directed table, hand sequences and random traffic vs a model.
module tb_sonic_sprite_fetch;

  localparam int W   = 40;
  localparam int H   = 40;
  localparam int FR  = 4;
  localparam int DIV = 8;
  localparam int AW  = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [9:0]    draw_x = '0, draw_y = '0, sprite_x = '0, sprite_y = '0;
  logic          blank = 1'b1, vsync_pulse = 1'b0, facing_left = 1'b0, moving = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_data = '0;
  logic [3:0]    pixel_index;
  logic          pixel_valid;
  logic [1:0]    frame_sel;

  sonic_sprite_fetch #(
    .SPRITE_W(W), .SPRITE_H(H), .FRAMES(FR), .ANIM_DIV(DIV), .ROM_AW(AW), .TRANSPARENT_IDX(0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .blank       (blank),
    .vsync_pulse (vsync_pulse),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .facing_left (facing_left),
    .moving      (moving),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_index (pixel_index),
    .pixel_valid (pixel_valid),
    .frame_sel   (frame_sel)
  );

  always #5 clk = ~clk;

  // Synchronous ROM stand-in: data appears one clock after the address.
  function automatic int rom_val(int a);
    return (a * 7 + 5) % 16;
  endfunction

  always @(posedge clk) rom_data <= 4'(rom_val(int'(rom_addr)));

  int checks = 0;
  int fails  = 0;

  int cur_sx = 0, cur_sy = 0, cur_face = 0, cur_mov = 0;
  int m_px = 0, m_py = 0, m_face = 0, m_pulses = 0;
  int hist_hit[$];
  int hist_addr[$];

  function automatic int model_frame();
    return (m_pulses / DIV) % FR;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_face = 0; m_pulses = 0;
    hist_hit.delete();
    hist_addr.delete();
  endtask

  // One pixel clock: drive, predict, clock, then compare at the falling edge.
  task automatic applyStimulus(int dx, int dy, int bl, int vs);
    int dxv, dyv, hit, lx, ly, col, addr;
    dxv = dx & 1023;
    dyv = dy & 1023;
    draw_x      = 10'(dxv);
    draw_y      = 10'(dyv);
    blank       = bl[0];
    vsync_pulse = vs[0];
    sprite_x    = 10'(cur_sx);
    sprite_y    = 10'(cur_sy);
    facing_left = cur_face[0];
    moving      = cur_mov[0];

    hit = (bl == 0 && dxv >= m_px && dxv < m_px + W && dyv >= m_py && dyv < m_py + H) ? 1 : 0;
    lx  = dxv - m_px;
    ly  = dyv - m_py;
    col = m_face ? (W - 1 - lx) : lx;
    addr = hit ? ((model_frame() * W * H + ly * W + col) % (1 << AW)) : 0;
    hist_hit.push_back(hit);
    hist_addr.push_back(addr);
    if (hist_hit.size() > 3) begin
      void'(hist_hit.pop_front());
      void'(hist_addr.pop_front());
    end
    if (vs != 0) begin
      m_px = cur_sx; m_py = cur_sy; m_face = cur_face;
      m_pulses = cur_mov ? m_pulses + 1 : 0;
    end

    @(posedge clk);
    @(negedge clk);
    checkOutput("rom_addr", int'(rom_addr), addr);
    checkOutput("frame_sel", int'(frame_sel), model_frame());
    if (hist_hit.size() == 3) begin
      checkOutput("pixel_index", int'(pixel_index), rom_val(hist_addr[0]));
      checkOutput("pixel_valid", int'(pixel_valid),
                  (hist_hit[0] != 0 && rom_val(hist_addr[0]) != 0) ? 1 : 0);
    end
  endtask

  task automatic pulse();
    applyStimulus(0, 0, 1, 1);
  endtask

  task automatic probe(string name, int dx, int dy, int bl, int ea, int ei, int ev);
    applyStimulus(dx, dy, bl, 0);
    checkOutput({name, " addr"}, int'(rom_addr), ea);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput({name, " index"}, int'(pixel_index), ei);
    checkOutput({name, " valid"}, int'(pixel_valid), ev);
  endtask

  typedef struct {
    int face;
    int dx;
    int dy;
    int bl;
    int exp_addr;
    int exp_idx;
    int exp_valid;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Sprite latched at (100,50); expected ROM contents are (addr*7+5) mod 16.
    vecs[0]  = '{0, 100, 50, 0,    0,  5, 1};
    vecs[1]  = '{0, 139, 50, 0,   39,  6, 1};
    vecs[2]  = '{0, 140, 50, 0,    0,  5, 0};
    vecs[3]  = '{0,  99, 50, 0,    0,  5, 0};
    vecs[4]  = '{0, 113, 50, 0,   13,  0, 0};
    vecs[5]  = '{0, 100, 50, 1,    0,  5, 0};
    vecs[6]  = '{0, 100, 89, 0, 1560, 13, 1};
    vecs[7]  = '{0, 100, 90, 0,    0,  5, 0};
    vecs[8]  = '{0, 139, 89, 0, 1599, 14, 1};
    vecs[9]  = '{1, 100, 51, 0,   79, 14, 1};
    vecs[10] = '{1, 139, 50, 0,    0,  5, 1};
    vecs[11] = '{1, 126, 50, 0,   13,  0, 0};

    $display("[TB] reset");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset rom_addr", int'(rom_addr), 0);
    checkOutput("reset pixel_index", int'(pixel_index), 0);
    checkOutput("reset pixel_valid", int'(pixel_valid), 0);
    checkOutput("reset frame_sel", int'(frame_sel), 0);
    reset_n = 1'b1;
    model_reset();

    $display("[TB] directed table");
    cur_sx = 100; cur_sy = 50; cur_face = 0; cur_mov = 0;
    pulse();
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].face != cur_face) begin
        cur_face = vecs[i].face;
        pulse();
      end
      probe($sformatf("vec%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].bl,
            vecs[i].exp_addr, vecs[i].exp_idx, vecs[i].exp_valid);
    end

    $display("[TB] mid-line reset");
    cur_face = 0;
    pulse();
    applyStimulus(100, 50, 0, 0);
    applyStimulus(101, 50, 0, 0);
    applyStimulus(102, 50, 0, 0);
    checkOutput("pre-reset pixel_valid", int'(pixel_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset pixel_valid", int'(pixel_valid), 0);
    checkOutput("async reset rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    $display("[TB] animation");
    pulse();
    cur_mov = 1;
    repeat (8) pulse();
    checkOutput("anim 8 pulses", int'(frame_sel), 1);
    repeat (8) pulse();
    checkOutput("anim 16 pulses", int'(frame_sel), 2);
    probe("frame2", 100, 50, 0, 3200, rom_val(3200), rom_val(3200) != 0 ? 1 : 0);
    repeat (16) pulse();
    checkOutput("anim 32 pulses wrap", int'(frame_sel), 0);
    repeat (8) pulse();
    checkOutput("anim 40 pulses", int'(frame_sel), 1);
    cur_mov = 0;
    pulse();
    checkOutput("anim stop", int'(frame_sel), 0);

    $display("[TB] mid-frame move");
    cur_sx = 200;
    probe("old pos hit", 105, 52, 0, 85, 8, 1);
    probe("new pos early", 205, 52, 0, 0, 5, 0);
    pulse();
    probe("new pos hit", 205, 52, 0, 85, 8, 1);
    probe("old pos miss", 105, 52, 0, 0, 5, 0);
    cur_sx = 300;
    applyStimulus(205, 52, 0, 1);
    checkOutput("vsync pixel uses old pos", int'(rom_addr), 85);
    applyStimulus(305, 52, 0, 0);
    checkOutput("after vsync new pos", int'(rom_addr), 85);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      int vs, bl, dx, dy;
      if ($urandom_range(0, 9) == 0) cur_sx = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) == 0) cur_sy = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) == 0) cur_face = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) cur_mov = ($urandom_range(0, 3) != 0) ? 1 : 0;
      vs = ($urandom_range(0, 19) == 0) ? 1 : 0;
      bl = ($urandom_range(0, 7) == 0) ? 1 : 0;
      dx = m_px - 5 + $urandom_range(0, 50);
      dy = m_py - 5 + $urandom_range(0, 50);
      applyStimulus(dx, dy, bl, vs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
